// File: rtl/hw_led_pkg.sv
// Shared definitions for the status-LED scheduler: FSM state encoding and blink-code width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hw_led_pkg;

  localparam int CODE_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  typedef enum logic [1:0] {
    stIdle = S_IDLE,
    stOn   = S_ON,
    stOff  = S_OFF,
    stGap  = S_GAP
  } ledState_t;

endpackage

// File: rtl/hw_tick_gen.sv
// Prescaler: one-cycle oTICK every FREQ/TICK_HZ cycles of iCLK.
// Latency: first tick DIV-1 cycles after reset release, then every DIV cycles.
// Backpressure: none; free-running.
// Ports: iCLK clock, iRST_n sync active-low reset, oTICK one-cycle tick strobe.
module hw_tick_gen #(
  parameter int FREQ    = 128000000,
  parameter int TICK_HZ = 10
) (
  input  logic iCLK,
  input  logic iRST_n,
  output logic oTICK
);

  localparam int DIV   = FREQ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] rCnt;

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      rCnt <= '0;
    end else if (rCnt == LAST) begin
      rCnt <= '0;
    end else begin
      rCnt <= rCnt + CNT_W'(1);
    end
  end

  assign oTICK = (rCnt == LAST);

endmodule

// File: rtl/hw_led_scheduler.sv
// Shares one status LED between N_REQ requesters: fixed-priority grant of one full blink sequence, heartbeat when idle.
// Latency: requests are sampled on the next tick (<= DIV cycles); oLED/oGRANT/oBUSY change on the tick edge itself.
// Backpressure: none; requests are level-held and simply wait while a sequence runs (no preemption).
// Ports: iCLK, iRST_n (sync active-low), iREQ[N_REQ] (bit 0 highest), iCODE[4*N_REQ],
//        oLED (1 = on), oGRANT one-hot owner, oBUSY high during ON/OFF/GAP.
module hw_led_scheduler
  import hw_led_pkg::*;
#(
  parameter int FREQ      = 128000000,
  parameter int TICK_HZ   = 10,
  parameter int N_REQ     = 4,
  parameter int GAP_TICKS = 4,
  parameter int HB_TICKS  = 5
) (
  input  logic                    iCLK,
  input  logic                    iRST_n,
  input  logic [N_REQ-1:0]        iREQ,
  input  logic [CODE_W*N_REQ-1:0] iCODE,
  output logic                    oLED,
  output logic [N_REQ-1:0]        oGRANT,
  output logic                    oBUSY
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS);
  // hb counts completed idle ticks; the toggle fires on the HB_TICKS-th one.
  localparam logic [7:0] HB_LAST  = 8'(HB_TICKS - 1);

  logic              tick;
  ledState_t         rState;
  logic [CODE_W-1:0] rCode;
  logic [3:0]        rPulse;
  logic [3:0]        rGap;
  logic [7:0]        rHb;

  logic              anyReq;
  logic [N_REQ-1:0]  winHot;
  logic [CODE_W-1:0] winCode;

  hw_tick_gen #(
    .FREQ    (FREQ),
    .TICK_HZ (TICK_HZ)
  ) uTick (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .oTICK  (tick)
  );

  // Scan from the top index down so the lowest requesting index wins.
  always_comb begin
    anyReq  = |iREQ;
    winHot  = '0;
    winCode = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (iREQ[k]) begin
        winHot    = '0;
        winHot[k] = 1'b1;
        winCode   = iCODE[k*CODE_W +: CODE_W];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      rState <= stIdle;
      oLED   <= 1'b0;
      oGRANT <= '0;
      oBUSY  <= 1'b0;
      rCode  <= '0;
      rPulse <= '0;
      rGap   <= '0;
      rHb    <= '0;
    end else if (tick) begin
      case (rState)
        stIdle: begin
          if (anyReq) begin
            rState <= stOn;
            rCode  <= winCode;
            oGRANT <= winHot;
            oBUSY  <= 1'b1;
            oLED   <= 1'b1;
            rPulse <= 4'd1;
          end else if (rHb == HB_LAST) begin
            oLED <= ~oLED;
            rHb  <= '0;
          end else begin
            rHb <= rHb + 8'd1;
          end
        end
        stOn: begin
          if (rCode == '0) begin
            // Solid code: LED left on; a held request is re-granted next tick.
            rState <= stIdle;
            oGRANT <= '0;
            oBUSY  <= 1'b0;
          end else begin
            rState <= stOff;
            oLED   <= 1'b0;
          end
        end
        stOff: begin
          if (rPulse != rCode) begin
            rPulse <= rPulse + 4'd1;
            rState <= stOn;
            oLED   <= 1'b1;
          end else begin
            rState <= stGap;
            rGap   <= 4'd1;
          end
        end
        stGap: begin
          if (rGap != GAP_LAST) begin
            rGap <= rGap + 4'd1;
          end else begin
            rState <= stIdle;
            oGRANT <= '0;
            oBUSY  <= 1'b0;
            rHb    <= '0;
          end
        end
        default: rState <= stIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_led_scheduler.sv
// Bench for hw_led_scheduler: directed scenarios with literal expectations plus randomized requests,
// all outputs compared every cycle against a tick-level model (position-in-sequence arithmetic).
// Small clock (FREQ=20, TICK_HZ=2 -> 10 cycles per tick) keeps sequences short.
module tb_hw_led_scheduler;

  localparam int FREQ  = 20;
  localparam int THZ   = 2;
  localparam int DIV   = FREQ / THZ;
  localparam int NREQ  = 4;
  localparam int GAP   = 4;
  localparam int HB    = 5;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic [3:0]  iREQ = '0;
  logic [15:0] iCODE = '0;
  logic        oLED;
  logic [3:0]  oGRANT;
  logic        oBUSY;

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  // Model state
  int mCnt = 0;
  bit tickFlag = 1'b0;
  bit mBusy = 1'b0;
  bit mLed = 1'b0;
  int mHb = 0;
  int mOwner = 0;
  int mCode = 0;
  int mK = 0;

  hw_led_scheduler #(
    .FREQ(FREQ), .TICK_HZ(THZ), .N_REQ(NREQ), .GAP_TICKS(GAP), .HB_TICKS(HB)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iREQ(iREQ), .iCODE(iCODE),
    .oLED(oLED), .oGRANT(oGRANT), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Model: mK = ticks since grant. Code C>=1 lights on even k below 2C, and is
  // over at k = 2C+GAP; code 0 is over after one tick with the LED left on.
  always @(posedge iCLK) begin
    if (!iRST_n) begin
      mCnt = 0; tickFlag = 0; mBusy = 0; mLed = 0; mHb = 0;
      mOwner = 0; mCode = 0; mK = 0;
    end else begin
      tickFlag = (mCnt == DIV - 1);
      mCnt = tickFlag ? 0 : mCnt + 1;
      if (tickFlag) begin
        if (!mBusy) begin
          if (iREQ != 0) begin
            for (int i = NREQ - 1; i >= 0; i--) if (iREQ[i]) mOwner = i;
            mCode = int'((iCODE >> (4 * mOwner)) & 16'hF);
            mK = 0; mBusy = 1; mLed = 1;
          end else begin
            mHb++;
            if (mHb == HB) begin mLed = !mLed; mHb = 0; end
          end
        end else begin
          mK++;
          if (mCode == 0) begin
            mBusy = 0; mLed = 1;
          end else if (mK == 2 * mCode + GAP) begin
            mBusy = 0; mLed = 0; mHb = 0;
          end else begin
            mLed = (mK < 2 * mCode) ? ((mK % 2) == 0) : 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge iCLK) begin
    if (chkEn) begin
      int expG;
      expG = mBusy ? (1 << mOwner) : 0;
      total++;
      if (oLED !== mLed || oBUSY !== mBusy || {28'd0, oGRANT} !== expG[31:0]) begin
        bad++;
        $display("FAIL model t=%0t: led=%b busy=%b grant=%b, want led=%b busy=%b grant=%0h",
                 $time, oLED, oBUSY, oGRANT, mLed, mBusy, expG);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next tick edge (bounded).
  task automatic nextTick();
    int guard = 0;
    do begin
      @(posedge iCLK); #1;
      guard++;
    end while (!tickFlag && guard < 3 * DIV);
    if (!tickFlag) begin
      total++; bad++;
      $display("FAIL tick_timeout: no tick within %0d cycles", guard);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (mBusy && n < 40) begin nextTick(); n++; end
    chk("idle_reached", {31'd0, mBusy}, 32'd0);
  endtask

  initial begin
    int pat3[10];
    pat3 = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    // 1. reset state and heartbeat
    repeat (3) @(posedge iCLK);
    #1;
    chkEn = 1'b1;
    chk("rst_led",   {31'd0, oLED},  32'd0);
    chk("rst_grant", {28'd0, oGRANT}, 32'd0);
    chk("rst_busy",  {31'd0, oBUSY}, 32'd0);
    @(negedge iCLK); iRST_n = 1'b1;
    repeat (49) @(posedge iCLK);
    #1 chk("hb_before_tick5", {31'd0, oLED}, 32'd0);
    @(posedge iCLK);
    #1 chk("hb_at_tick5", {31'd0, oLED}, 32'd1);
    repeat (49) @(posedge iCLK);
    #1 chk("hb_before_tick10", {31'd0, oLED}, 32'd1);
    @(posedge iCLK);
    #1 chk("hb_at_tick10", {31'd0, oLED}, 32'd0);

    // 2. requester 2, code 3, held
    iREQ = 4'b0100; iCODE = 16'h0300;
    nextTick();
    chk("c3_grant", {28'd0, oGRANT}, 32'h4);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nextTick();
      chk("c3_led", {31'd0, oLED}, pat3[i]);
      chk("c3_busy", {31'd0, oBUSY}, 32'd1);
    end
    nextTick();
    chk("c3_end_busy", {31'd0, oBUSY}, 32'd0);
    chk("c3_end_grant", {28'd0, oGRANT}, 32'd0);
    nextTick();
    chk("c3_regrant", {28'd0, oGRANT}, 32'h4);
    iREQ = 4'b0000;
    waitIdle();

    // 3. no preemption
    iREQ = 4'b0100; iCODE = 16'h0200;
    nextTick();
    chk("np_grant2", {28'd0, oGRANT}, 32'h4);
    iREQ = 4'b0101; iCODE = 16'h0201;
    for (int i = 1; i < 8; i++) begin
      nextTick();
      chk("np_hold2", {28'd0, oGRANT}, 32'h4);
    end
    iREQ = 4'b0001;
    nextTick();
    chk("np_idle", {28'd0, oGRANT}, 32'd0);
    nextTick();
    chk("np_grant0", {28'd0, oGRANT}, 32'h1);
    chk("np_led_on", {31'd0, oLED}, 32'd1);
    iREQ = 4'b0000;
    nextTick();
    chk("np_led_off", {31'd0, oLED}, 32'd0);
    waitIdle();

    // 4. code 0 held three ticks
    iREQ = 4'b0010; iCODE = 16'h0000;
    nextTick(); chk("c0_g1", {28'd0, oGRANT}, 32'h2); chk("c0_l1", {31'd0, oLED}, 32'd1);
    nextTick(); chk("c0_g2", {28'd0, oGRANT}, 32'h0); chk("c0_l2", {31'd0, oLED}, 32'd1);
    nextTick(); chk("c0_g3", {28'd0, oGRANT}, 32'h2); chk("c0_b3", {31'd0, oBUSY}, 32'd1);
    iREQ = 4'b0000;
    nextTick(); chk("c0_g4", {28'd0, oGRANT}, 32'h0); chk("c0_l4", {31'd0, oLED}, 32'd1);

    // 5. reset during OFF of a code-5 sequence
    iREQ = 4'b1000; iCODE = 16'h5000;
    nextTick(); chk("r5_grant", {28'd0, oGRANT}, 32'h8);
    nextTick(); chk("r5_off", {31'd0, oLED}, 32'd0);
    iREQ = 4'b0000;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK); iRST_n = 1'b0;
    @(posedge iCLK);
    #1 chk("r5_led", {31'd0, oLED}, 32'd0);
    chk("r5_gr", {28'd0, oGRANT}, 32'd0);
    chk("r5_busy", {31'd0, oBUSY}, 32'd0);
    @(negedge iCLK); iRST_n = 1'b1; iREQ = 4'b0001; iCODE = 16'h0001;
    repeat (9) @(posedge iCLK);
    #1 chk("r5_no_tick_yet", {28'd0, oGRANT}, 32'd0);
    @(posedge iCLK);
    #1 chk("r5_tick10", {28'd0, oGRANT}, 32'h1);
    iREQ = 4'b0000;
    waitIdle();

    // 6. short pulse between ticks is never granted
    nextTick();
    repeat (2) @(posedge iCLK);
    #1 iREQ = 4'b1000;
    repeat (3) @(posedge iCLK);
    #1 iREQ = 4'b0000;
    nextTick(); chk("pulse_ng1", {28'd0, oGRANT}, 32'd0);
    nextTick(); chk("pulse_ng2", {28'd0, oGRANT}, 32'd0);

    // Randomized requests, codes 0..7, occasional reset
    for (int c = 0; c < 6000; c++) begin
      @(negedge iCLK);
      iRST_n = 1'b1;
      if ($urandom_range(0, 15) == 0) iREQ = 4'($urandom);
      if ($urandom_range(0, 31) == 0) iCODE = 16'($urandom) & 16'h7777;
      if ($urandom_range(0, 1999) == 0) iRST_n = 1'b0;
    end
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    chkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
